normalize_round: RTL and testbench
==================================

NORMALIZE_ROUND -- requirements
Module: normalize_round

Interface
REQ-001 SHALL have parameter E_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter M_WIDTH, default 23, stored fraction width.
REQ-003 SHALL have one clock and one reset: port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, raw sum present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a sum.
REQ-007 SHALL have port sign_in, input, 1, sign of raw sum.
REQ-008 SHALL have port exp_in, input, E_WIDTH, biased exponent of the larger operand.
REQ-009 SHALL have port sum_in, input, M_WIDTH+5, carry at M+4, hidden at M+3, fraction at [M+2:3], guard/round/sticky at [2:0].
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port result, output, 1+E_WIDTH+M_WIDTH, packed as {sign, exp, fraction}.
REQ-013 SHALL have port overflow, output, 1, result saturated to infinity.
REQ-014 SHALL have port zero, output, 1, result is exact zero.

Function
REQ-015 SHALL implement states IDLE, NORM, ROUND, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-016 SHALL in IDLE, on in_valid, load sign, exponent and sum, and go to NORM; exp_in=0 is loaded as 1; callers SHALL keep exp_in below all-ones.
REQ-017 SHALL in NORM, evaluate one branch per cycle, in this priority:
- carry=1: shift right by 1 with the dropped bit ORed into sticky, exponent+1, then ROUND.
- sum=0: go to ROUND.
- hidden=1 or exponent=1: go to ROUND.
- otherwise: shift left by 1, exponent-1, stay in NORM.
REQ-018 SHALL in ROUND, apply round-to-nearest-even:
- Increment the fraction when G & (R | S | LSB).
- A fraction carry-out sets exponent+1 and leaves the fraction 0.
- Then go to DONE.
REQ-019 SHALL encode the exponent field as 0 when the hidden bit is 0 after rounding (denormal).
- If rounding sets the hidden bit at exponent 1, the field SHALL be 1.
REQ-020 SHALL force result to {sign, all-ones, 0} with overflow=1 when the exponent reaches all-ones, after the carry shift or after rounding.
REQ-021 SHALL force result to all zeros, sign 0, with zero=1 when sum_in=0.
REQ-022 SHALL hold result, overflow and zero stable in DONE until out_ready=1, then go to IDLE, so in_ready=1 in the next cycle.
REQ-023 SHALL have latency as follows:
- Accept at edge k; for zero, carry, or already-normalized input, out_valid=1 after edge k+2.
- Each left shift adds one cycle.
REQ-024 SHALL ignore in_valid outside IDLE, with no input capture.

Reset
REQ-025 SHALL, while rst=1, force state IDLE regardless of clk.
- in_ready=1; out_valid=0; result=0; overflow=0; zero=0; internal registers 0.
REQ-026 SHALL on rst during NORM, ROUND or DONE discard the operation, and SHALL produce no output after release.

Verification (E_WIDTH=8, M_WIDTH=23)
REQ-027 SHALL cover: hidden=1, fraction=0, grs=0, exp_in=127, sign 0 -> result 0x3F800000 with out_valid after edge k+2.
REQ-028 SHALL cover: carry=1, other bits 0, exp_in=127 -> result 0x40000000.
REQ-029 SHALL cover: only bit M+0 set, exp_in=130 -> result 0x3F800000 after 3 extra NORM cycles (out_valid after edge k+5).
REQ-030 SHALL cover: hidden=1, fraction all-ones, grs=100, exp_in=127 -> result 0x40000000 (round carry-out).
REQ-031 SHALL cover: carry=1, exp_in=254, sign 1 -> result 0xFF800000 with overflow=1; separately, sum_in=0, sign 1 -> result 0x00000000 with zero=1.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles, then rst pulsed during a NORM left-shift sequence -> output stable while held, then out_valid=0 and in_ready=1 immediately with no stale result.

Source files
------------

// File: rtl/normalize_round.sv
// normalize_round: takes a raw significand sum, normalizes it one bit per
// cycle, rounds to nearest-even and packs {sign, exp, fraction}.
// The result is held in DONE until the consumer takes it.
module normalize_round #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       sign_in,
  input  logic [E_WIDTH-1:0]         exp_in,
  input  logic [M_WIDTH+4:0]         sum_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [E_WIDTH+M_WIDTH:0]   result,
  output logic                       overflow,
  output logic                       zero
);

  localparam int SW = M_WIDTH + 5;
  localparam logic [E_WIDTH-1:0] EXP_MAX = '1;
  localparam logic [E_WIDTH-1:0] EXP_ONE = {{(E_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      sign_q, sign_d;
  logic [E_WIDTH-1:0]        exp_q, exp_d;
  logic [SW-1:0]             sum_q, sum_d;
  logic [E_WIDTH+M_WIDTH:0]  result_q, result_d;
  logic                      overflow_q, overflow_d;
  logic                      zero_q, zero_d;

  logic                      round_up;
  logic [M_WIDTH+1:0]        mant_rnd;
  logic [E_WIDTH-1:0]        exp_rnd;
  logic [E_WIDTH-1:0]        exp_field;
  logic [M_WIDTH-1:0]        frac_rnd;
  logic                      hid_rnd;

  // Round-to-nearest-even on {hidden, fraction} using guard/round/sticky.
  always_comb begin
    round_up  = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    mant_rnd  = {1'b0, sum_q[M_WIDTH+3:3]} + {{(M_WIDTH+1){1'b0}}, round_up};
    exp_rnd   = exp_q;
    frac_rnd  = mant_rnd[M_WIDTH-1:0];
    hid_rnd   = mant_rnd[M_WIDTH];
    if (mant_rnd[M_WIDTH+1]) begin
      // Fraction carry-out: significand becomes 1.000..., bump exponent.
      exp_rnd  = exp_q + EXP_ONE;
      frac_rnd = '0;
      hid_rnd  = 1'b1;
    end
    // A cleared hidden bit means a denormal, whose exponent field is 0.
    exp_field = hid_rnd ? exp_rnd : '0;
  end

  // Next-state logic and datapath updates for the four-state sequencer.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    sum_d      = sum_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sign_in;
          // Exponent 0 (denormal input) behaves as exponent 1 internally.
          exp_d   = (exp_in == '0) ? EXP_ONE : exp_in;
          sum_d   = sum_in;
          state_d = NORM;
        end
      end
      NORM: begin
        if (sum_q[SW-1]) begin
          // Carry out of the add: shift right, keep dropped bit in sticky.
          sum_d   = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = ROUND;
        end else if (sum_q == '0) begin
          state_d = ROUND;
        end else if (sum_q[SW-2] || (exp_q == EXP_ONE)) begin
          state_d = ROUND;
        end else begin
          sum_d   = {sum_q[SW-2:0], 1'b0};
          exp_d   = exp_q - EXP_ONE;
        end
      end
      ROUND: begin
        state_d = DONE;
        if (sum_q == '0) begin
          result_d   = '0;
          overflow_d = 1'b0;
          zero_d     = 1'b1;
        end else if ((exp_q == EXP_MAX) || (exp_rnd == EXP_MAX)) begin
          result_d   = {sign_q, EXP_MAX, {M_WIDTH{1'b0}}};
          overflow_d = 1'b1;
          zero_d     = 1'b0;
        end else begin
          result_d   = {sign_q, exp_field, frac_rnd};
          overflow_d = 1'b0;
          zero_d     = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      sum_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_normalize_round.sv
// tb_normalize_round: directed vectors with hand-computed single-precision
// results, latency, hold-while-stalled and reset-abort checks.
module tb_normalize_round;

  localparam int E = 8;
  localparam int M = 23;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             sign_in;
  logic [E-1:0]     exp_in;
  logic [M+4:0]     sum_in;
  logic             out_valid;
  logic             out_ready;
  logic [E+M:0]     result;
  logic             overflow;
  logic             zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  normalize_round #(.E_WIDTH(E), .M_WIDTH(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .sum_in    (sum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // One transaction: present a sum, wait for the result, optionally stall
  // the consumer, then hand the result off.
  task automatic run_op(input string tag, input logic sg, input logic [E-1:0] ex,
                        input logic [M+4:0] sm, input logic [31:0] want,
                        input logic w_ovf, input logic w_zero, input int lat,
                        input bit junk, input int hold);
    int n;
    chk({tag, "/in_ready"}, in_ready, 1);
    in_valid = 1'b1; sign_in = sg; exp_in = ex; sum_in = sm;
    @(posedge clk); #1;
    if (junk) begin
      // Busy: this different operand must not be captured.
      in_valid = 1'b1; sign_in = ~sg; exp_in = 8'd5; sum_in = '0;
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "/latency"}, n, lat);
    chk({tag, "/result"}, result, want);
    chk({tag, "/overflow"}, overflow, w_ovf);
    chk({tag, "/zero"}, zero, w_zero);
    $display("op %s: result=0x%h overflow=%b zero=%b latency=%0d", tag, result, overflow, zero, n);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, out_valid, 1);
      chk({tag, "/hold_result"}, result, want);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/ready_after"}, in_ready, 1);
    chk({tag, "/valid_after"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; sum_in = '0; out_ready = 1'b0;
    #12;
    chk("reset/in_ready", in_ready, 1);
    chk("reset/out_valid", out_valid, 0);
    chk("reset/result", result, 0);
    chk("reset/overflow", overflow, 0);
    chk("reset/zero", zero, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("normal_one",   1'b0, 8'd127, 28'h4000000, 32'h3F800000, 0, 0, 2, 0, 0);
    run_op("carry",        1'b0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 2, 0, 0);
    run_op("shift3",       1'b0, 8'd130, 28'h0800000, 32'h3F800000, 0, 0, 5, 1, 0);
    run_op("round_carry",  1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 0, 0, 2, 0, 0);
    run_op("ovf_carry",    1'b1, 8'd254, 28'h8000000, 32'hFF800000, 1, 0, 2, 0, 0);
    run_op("zero",         1'b1, 8'd100, 28'h0000000, 32'h00000000, 0, 1, 2, 0, 0);
    run_op("tie_even",     1'b0, 8'd127, 28'h4000004, 32'h3F800000, 0, 0, 2, 0, 0);
    run_op("tie_odd",      1'b0, 8'd127, 28'h400000C, 32'h3F800002, 0, 0, 2, 0, 0);
    run_op("sticky_shift", 1'b0, 8'd127, 28'h8000009, 32'h40000001, 0, 0, 2, 0, 0);
    run_op("denorm",       1'b0, 8'd0,   28'h2000000, 32'h00400000, 0, 0, 2, 0, 0);
    run_op("denorm_up",    1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 0, 0, 2, 0, 0);
    run_op("shift_to_e1",  1'b0, 8'd2,   28'h1000000, 32'h00400000, 0, 0, 3, 0, 0);
    run_op("ovf_round",    1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 1, 0, 2, 0, 0);
    run_op("stall5",       1'b1, 8'd127, 28'h4000000, 32'hBF800000, 0, 0, 2, 0, 5);

    // Abort a left-shift sequence with an asynchronous reset pulse.
    in_valid = 1'b1; sign_in = 1'b0; exp_in = 8'd130; sum_in = 28'h0800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort/busy", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("abort/in_ready", in_ready, 1);
    chk("abort/out_valid", out_valid, 0);
    chk("abort/result", result, 0);
    chk("abort/overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort/no_output", out_valid, 0);
    end
    $display("op abort: reset during NORM, in_ready=%b out_valid=%b result=0x%h", in_ready, out_valid, result);

    run_op("after_abort",  1'b0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
